lsu_mem_adapter: RTL and testbench

Load/store adapter between the CPU memory stage and a 32-bit synchronous-read, byte-write-enable data RAM. The RAM has one-cycle read latency and per-byte write enables. The block turns byte, half and word requests at arbitrary byte addresses into RAM word accesses. A request that crosses a word boundary is split into two consecutive accesses. Load data is aligned and sign- or zero-extended, and one response per request is returned to the pipeline.

---
 rtl/lsu_mem_adapter.sv | 190 +++++++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter: maps byte/half/word CPU requests at any byte address onto a
// 32-bit synchronous-read RAM with byte write enables, splitting word-crossing accesses.
module lsu_mem_adapter #(
   parameter int AWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_d,
   output logic [3:0]        mem_wbe,
   input  logic [31:0]       mem_q
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_e;

   // Byte lanes touched by a request of this size, before the offset shift.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return (off == 2'd3);
         default: return (off != 2'd0);
      endcase
   endfunction

   // Lane mask for access A (hi = 0) or access B (hi = 1).
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off,
                                            input logic hi);
      logic [7:0] m;
      m = {4'b0000, size_mask(size)} << off;
      return hi ? m[7:4] : m[3:0];
   endfunction

   function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] off,
                                             input logic hi);
      logic [63:0] d;
      d = {32'h0, wdata} << {off, 3'b000};
      return hi ? d[63:32] : d[31:0];
   endfunction

   // pair = {word B, word A}; right-justify the addressed bytes and extend.
   function automatic logic [31:0] format_load(input logic [63:0] pair, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = 32'(pair >> {off, 3'b000});
      case (size)
         2'b00:   r = {{24{~uns & sh[7]}}, sh[7:0]};
         2'b01:   r = {{16{~uns & sh[15]}}, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          off_q, off_d;
   logic [AWIDTH-1:0]   waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         lo_q, lo_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;

   logic                accept;
   logic                split_q;
   logic                issue_b;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

   assign req_ready = rst && (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign split_q   = is_split(size_q, off_q);
   assign issue_b   = (state_q == ST_LO) && split_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

   // RAM pins: access A straight from the request, access B from the latched fields.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
      mem_addr = req_addr[AWIDTH+1:2];
      mem_wbe  = 4'b0000;
      mem_d    = 32'h0;
      if (accept) begin
         if (req_we) begin
            mem_wbe = lane_mask(req_size, req_addr[1:0], 1'b0);
            mem_d   = lane_data(req_wdata, req_addr[1:0], 1'b0);
         end
      end else if (issue_b) begin
         mem_addr = waddr_q + AWIDTH'(1);
         if (we_q) begin
            mem_wbe = lane_mask(size_q, off_q, 1'b1);
            mem_d   = lane_data(wdata_q, off_q, 1'b1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               waddr_d = req_addr[AWIDTH+1:2];
               wdata_d = req_wdata;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            if (split_q) begin
               lo_d    = mem_q;
               state_d = ST_HI;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? 32'h0 : format_load({32'h0, mem_q}, size_q, off_q, uns_q);
               state_d     = ST_IDLE;
            end
         end
         ST_HI: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'h0 : format_load({mem_q, lo_q}, size_q, off_q, uns_q);
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         waddr_q     <= '0;
         wdata_q     <= 32'h0;
         lo_q        <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments, so every flop updates from pre-edge values.
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         lo_q        <= lo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: behavioural RAM, byte-array reference model, a table of
// directed vectors, hand-written multi-cycle sequences and randomized traffic.
module tb_lsu_mem_adapter;

   localparam int AW    = 14;
   localparam int WORDS = 1 << AW;
   localparam int BYTES = 4 * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_d;
   logic [3:0]    mem_wbe;
   logic [31:0]   mem_q;

   int total = 0;
   int bad   = 0;

   lsu_mem_adapter #(.AWIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_d        (mem_d),
      .mem_wbe      (mem_wbe),
      .mem_q        (mem_q)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int w);
      return (32'(w) * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   // Synchronous-read RAM with per-byte write enables (read returns pre-write data).
   logic [31:0] ram [0:WORDS-1];
   initial begin
      for (int w = 0; w < WORDS; w++) ram[w] = init_word(w);
      forever begin
         @(posedge clk);
         mem_q <= ram[mem_addr];
         for (int i = 0; i < 4; i++)
            if (mem_wbe[i]) ram[mem_addr][8*i +: 8] = mem_d[8*i +: 8];
      end
   end

   // Reference model: a flat byte array addressed modulo the byte space.
   logic [7:0] model_mem [0:BYTES-1];

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp, output int exp_lat);
      int          n;
      int unsigned base;
      int unsigned idx;
      logic [31:0] v;
      n    = nbytes(size);
      base = addr % BYTES;
      v    = 32'h0;
      for (int i = 0; i < n; i++) begin
         idx = (base + i) % BYTES;
         if (we) model_mem[idx] = wdata[8*i +: 8];
         else    v = v | (32'(model_mem[idx]) << (8*i));
      end
      if (!we && !uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp     = we ? 32'h0 : v;
      exp_lat = ((addr % 4) + n > 4) ? 3 : 2;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
      end
   endtask

   logic [AW-1:0] cap_addr [0:1];
   logic [3:0]    cap_wbe  [0:1];
   logic [31:0]   cap_d    [0:1];

   // Issue one request starting at a negedge; returns response data and its cycle index.
   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      #1;
      check("accept_ready", 32'(req_ready), 32'd1);
      cap_addr[0] = mem_addr;
      cap_wbe[0]  = mem_wbe;
      cap_d[0]    = mem_d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat   = 0;
      rdata = 'x;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cap_addr[1] = mem_addr;
            cap_wbe[1]  = mem_wbe;
            cap_d[1]    = mem_d;
         end
         if (rsp_valid) begin
            lat   = k;
            rdata = rsp_rdata;
            break;
         end
      end
      if (lat != 0) begin
         @(negedge clk);
         check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_lat);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, exp, w;
      int          lat, exp_lat;
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;

      for (int wi = 0; wi < WORDS; wi++) begin
         w = init_word(wi);
         for (int b = 0; b < 4; b++) model_mem[4*wi + b] = w[8*b +: 8];
      end

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_mem_wbe", 32'(mem_wbe), 32'd0);
      rst = 1'b1;
      #1;
      check("release_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      // we size uns addr wdata exp_rdata exp_lat
      add_vec(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,          2);
      add_vec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF,  2);
      add_vec(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_0000, 32'h0,          2);
      add_vec(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,         32'hFFFF_FF80,  2);
      add_vec(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,         32'h0000_0080,  2);
      add_vec(1'b0, 2'd1, 1'b0, 32'h12, 32'h0,         32'hFFFF_80FF,  2);
      add_vec(1'b0, 2'd1, 1'b1, 32'h12, 32'h0,         32'h0000_80FF,  2);
      add_vec(1'b0, 2'd0, 1'b0, 32'h12, 32'h0,         32'hFFFF_FFFF,  2);
      add_vec(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_565A, 32'h0,          2);
      add_vec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'h80FF_5A00,  2);
      add_vec(1'b0, 2'd0, 1'b0, 32'h11, 32'h0,         32'h0000_005A,  2);
      add_vec(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_C0DE, 32'h0,          3);
      add_vec(1'b0, 2'd1, 1'b1, 32'h13, 32'h0,         32'h0000_C0DE,  3);
      add_vec(1'b0, 2'd1, 1'b0, 32'h13, 32'h0,         32'hFFFF_C0DE,  3);
      add_vec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hDEFF_5A00,  2);
      add_vec(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,         32'hDEFF_5A00,  2);
      add_vec(1'b0, 2'd0, 1'b1, 32'h14, 32'h0,         32'h0000_00C0,  2);

      foreach (vecs[i]) begin
         model_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                      exp, exp_lat);
         run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, got, lat);
         check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      end

      // Aligned store: pins in the accept cycle.
      model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got, lat);
      check("st_al_addr", 32'(cap_addr[0]), 32'd4);
      check("st_al_wbe", 32'(cap_wbe[0]), 32'b1111);
      check("st_al_d", cap_d[0], 32'hDEAD_BEEF);
      check("st_al_latency", 32'(lat), 32'd2);

      // Split store then split load across words 3/4.
      model_access(1'b1, 2'd2, 1'b0, 32'h0D, 32'h1122_3344, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'h0D, 32'h1122_3344, got, lat);
      check("st_sp_a_addr", 32'(cap_addr[0]), 32'd3);
      check("st_sp_a_wbe", 32'(cap_wbe[0]), 32'b1110);
      check("st_sp_a_d", cap_d[0], 32'h2233_4400);
      check("st_sp_b_addr", 32'(cap_addr[1]), 32'd4);
      check("st_sp_b_wbe", 32'(cap_wbe[1]), 32'b0001);
      check("st_sp_b_d", cap_d[1], 32'h0000_0011);
      check("st_sp_latency", 32'(lat), 32'd3);
      check("st_sp_rdata", got, 32'h0);
      model_access(1'b0, 2'd2, 1'b0, 32'h0D, 32'h0, exp, exp_lat);
      run_req(1'b0, 2'd2, 1'b0, 32'h0D, 32'h0, got, lat);
      check("ld_sp_rdata", got, 32'h1122_3344);
      check("ld_sp_latency", 32'(lat), 32'd3);
      check("ld_sp_wbe_a", 32'(cap_wbe[0]), 32'd0);
      check("ld_sp_wbe_b", 32'(cap_wbe[1]), 32'd0);

      // Wrap from the top word to word 0.
      model_access(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, got, lat);
      model_access(1'b1, 2'd2, 1'b0, 32'(BYTES - 4), 32'hAB00_0000, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'(BYTES - 4), 32'hAB00_0000, got, lat);
      run_req(1'b0, 2'd1, 1'b1, 32'(BYTES - 1), 32'h0, got, lat);
      check("wrap_a_addr", 32'(cap_addr[0]), 32'(WORDS - 1));
      check("wrap_b_addr", 32'(cap_addr[1]), 32'd0);
      check("wrap_rdata", got, 32'h0000_78AB);
      check("wrap_latency", 32'(lat), 32'd3);

      // Clear words 8 and 9 for the reset test.
      model_access(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, got, lat);
      model_access(1'b1, 2'd2, 1'b0, 32'h24, 32'h0, exp, exp_lat);
      run_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h0, got, lat);

      // Back-to-back aligned loads with req_valid held.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      #1;
      check("b2b_ready_c0", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_addr = 32'h10;
      @(negedge clk);
      check("b2b_ready_c1", 32'(req_ready), 32'd0);
      check("b2b_rsp_c1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("b2b_rsp_c2", 32'(rsp_valid), 32'd1);
      check("b2b_data_c2", rsp_rdata, 32'h1234_5678);
      check("b2b_ready_c2", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b_rsp_c3", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("b2b_rsp_c4", 32'(rsp_valid), 32'd1);
      check("b2b_data_c4", rsp_rdata, 32'hDEAD_BE11);
      @(negedge clk);
      check("b2b_rsp_c5", 32'(rsp_valid), 32'd0);

      // Reset in cycle 1 of a split store: access A stands, access B never commits.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h5566_7788;
      #1;
      check("rst_a_wbe", 32'(mem_wbe), 32'b1110);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rst_b_pending_wbe", 32'(mem_wbe), 32'b0001);
      rst = 1'b0;
      #1;
      check("rst_mid_wbe", 32'(mem_wbe), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd0);
      check("rst_mid_rdata", rsp_rdata, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("rst_hold%0d_rsp", k), 32'(rsp_valid), 32'd0);
         check($sformatf("rst_hold%0d_ready", k), 32'(req_ready), 32'd0);
         check($sformatf("rst_hold%0d_wbe", k), 32'(mem_wbe), 32'd0);
      end
      rst = 1'b1;
      #1;
      check("rst_release_ready", 32'(req_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rst_after%0d_rsp", k), 32'(rsp_valid), 32'd0);
      end
      for (int i = 0; i < 3; i++) model_mem[32'h21 + i] = r_wdata_byte(32'h5566_7788, i);
      run_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, got, lat);
      check("rst_word9_untouched", got, 32'h0);
      run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got, lat);
      check("rst_word8_access_a", got, 32'h6677_8800);

      // Randomized traffic against the byte-array model.
      for (int it = 0; it < 400; it++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_size  = 2'($urandom_range(0, 3));
         r_uns   = 1'($urandom_range(0, 1));
         r_wdata = $urandom;
         case ($urandom_range(0, 3))
            0:       r_addr = $urandom;
            1:       r_addr = 32'(BYTES - 8 + int'($urandom_range(0, 7)));
            default: r_addr = 32'($urandom_range(0, 63));
         endcase
         model_access(r_we, r_size, r_uns, r_addr, r_wdata, exp, exp_lat);
         run_req(r_we, r_size, r_uns, r_addr, r_wdata, got, lat);
         check($sformatf("rand%0d_rdata", it), got, exp);
         check($sformatf("rand%0d_latency", it), 32'(lat), 32'(exp_lat));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [7:0] r_wdata_byte(input logic [31:0] data, input int i);
      return data[8*i +: 8];
   endfunction

endmodule
